// File: rtl/sign_magnitude_decoder_pkg.sv
// Shared types and defaults for the sign-magnitude decoder: FSM state
// encoding, default word/chunk sizes and the chunk-index width helper.
package sign_mag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 32;
  localparam int CHUNK_DEF = 8;

  // A single-chunk word still needs a 1-bit index register.
  function automatic int idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/sign_magnitude_decoder_if.sv
// Operand/result handshake bundle between the result bus and the decoder.
interface sign_magnitude_decoder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [WIDTH-1:0] out_mag;
  logic             out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_mag, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_mag, out_zero
  );
endinterface

// File: rtl/sign_magnitude_decoder_chunk_negate_slice.sv
// One CHUNK-bit slice of two's-complement negation: sum = ~a + cin.
module chunk_negate_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, ~a} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/sign_magnitude_decoder.sv
// Two's-complement to sign-magnitude converter; negative operands are
// negated one CHUNK slice per cycle through a single registered-carry slice.
module sign_magnitude_decoder
  import sign_mag_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  sign_magnitude_decoder_if.slave   bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_w(NCHUNK);

  if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_width
    $error("sign_magnitude_decoder: WIDTH must be a nonzero multiple of CHUNK");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  op_q, op_d;
  logic [WIDTH-1:0]  mag_q, mag_d;
  logic              sign_q, sign_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
  logic [IW-1:0]     idx_q, idx_d;

  logic              accept;
  logic              last_chunk;
  logic [NCHUNK-1:0] mag_we;
  logic [CHUNK-1:0]  op_slice;
  logic [CHUNK-1:0]  neg_sum;
  logic              neg_cout;

  assign accept     = bus.in_valid && bus.in_ready;
  assign last_chunk = (idx_q == IW'(NCHUNK - 1));
  assign op_slice   = op_q[int'(idx_q) * CHUNK +: CHUNK];

  chunk_negate_slice #(.CHUNK(CHUNK)) u_neg (
    .a   (op_slice),
    .cin (carry_q),
    .sum (neg_sum),
    .cout(neg_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bus.in_data[WIDTH-1] ? CONV : DONE;
      CONV:    if (last_chunk) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < NCHUNK; k++) begin
      mag_we[k] = (state_q == CONV) && (idx_q == IW'(k));
    end
  end

  // Operand capture on accept, then one negated slice per CONV cycle.
  always_comb begin
    op_d    = op_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    if (state_q == IDLE && accept) begin
      op_d    = bus.in_data;
      sign_d  = bus.in_data[WIDTH-1];
      zero_d  = (bus.in_data == '0);
      carry_d = 1'b1;
      idx_d   = '0;
      if (!bus.in_data[WIDTH-1]) mag_d = bus.in_data;
    end else if (state_q == CONV) begin
      for (int k = 0; k < NCHUNK; k++) begin
        if (mag_we[k]) mag_d[k*CHUNK +: CHUNK] = neg_sum;
      end
      carry_d = neg_cout;
      idx_d   = last_chunk ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE) && !rst;
    bus.out_valid = (state_q == DONE);
    bus.out_sign  = sign_q;
    bus.out_mag   = mag_q;
    bus.out_zero  = zero_q;
  end

endmodule

// File: tb/tb_sign_magnitude_decoder.sv
// Directed bench for sign_magnitude_decoder: latency, values, backpressure
// and mid-conversion reset.
module tb_sign_magnitude_decoder;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   lat;

  sign_magnitude_decoder_if #(.WIDTH(32)) bus ();

  sign_magnitude_decoder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word for a single accept edge, then count cycles to out_valid.
  task automatic send(input logic [31:0] data);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic expect_result(input string tag, input int exp_lat, input logic exp_sign,
                               input logic [31:0] exp_mag, input logic exp_zero);
    check({tag, "_lat"},  32'(lat),           32'(exp_lat));
    check({tag, "_vld"},  32'(bus.out_valid), 32'd1);
    check({tag, "_sign"}, 32'(bus.out_sign),  32'(exp_sign));
    check({tag, "_mag"},  bus.out_mag,        exp_mag);
    check({tag, "_zero"}, 32'(bus.out_zero),  32'(exp_zero));
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, "_hs_vld"},   32'(bus.out_valid), 32'd0);
    check({tag, "_hs_ready"}, 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sign",  32'(bus.out_sign),  32'd0);
    check("rst_out_mag",   bus.out_mag,        32'd0);
    check("rst_out_zero",  32'(bus.out_zero),  32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);

    bus.out_ready = 1'b1;
    send(32'h0000_0005);
    expect_result("pos5", 1, 1'b0, 32'h0000_0005, 1'b0);
    handshake("pos5");

    send(32'hFFFF_FFFB);
    expect_result("neg5", 5, 1'b1, 32'h0000_0005, 1'b0);
    handshake("neg5");

    send(32'hFFFF_FF00);
    expect_result("ff00", 5, 1'b1, 32'h0000_0100, 1'b0);
    handshake("ff00");

    send(32'hFFFF_FFFF);
    expect_result("m1", 5, 1'b1, 32'h0000_0001, 1'b0);
    handshake("m1");

    send(32'h8000_0000);
    expect_result("minint", 5, 1'b1, 32'h8000_0000, 1'b0);
    handshake("minint");

    send(32'h0000_0000);
    expect_result("zero", 1, 1'b0, 32'h0000_0000, 1'b1);
    handshake("zero");

    // Backpressure with garbage on the input side.
    send(32'h0000_1234);
    expect_result("bp", 1, 1'b0, 32'h0000_1234, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = 32'hF0F0_0000 + 32'(i);
      step();
      check("bp_hold_vld",   32'(bus.out_valid), 32'd1);
      check("bp_hold_mag",   bus.out_mag,        32'h0000_1234);
      check("bp_hold_sign",  32'(bus.out_sign),  32'd0);
      check("bp_hold_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.in_valid = 1'b0;
    handshake("bp");
    send(32'h7FFF_FFFF);
    expect_result("after_bp", 1, 1'b0, 32'h7FFF_FFFF, 1'b0);
    handshake("after_bp");

    // Reset in the second CONV cycle discards the partial result.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_FFFB;
    step();
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("midrst_vld",   32'(bus.out_valid), 32'd0);
    check("midrst_mag",   bus.out_mag,        32'd0);
    check("midrst_ready", 32'(bus.in_ready),  32'd0);
    rst = 1'b0;
    #1;
    check("midrst_idle_ready", 32'(bus.in_ready), 32'd1);
    send(32'hFFFF_FFF6);
    expect_result("neg10", 5, 1'b1, 32'h0000_000A, 1'b0);
    handshake("neg10");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sign_magnitude_decoder.md
# sign_magnitude_decoder

Multi-cycle converter that takes a 32-bit two's-complement word and returns its sign bit plus unsigned magnitude. It is the decode direction of the ALU's complement path: it undoes invert-and-add-one negation. It sits between the datapath result bus and display/debug consumers that need sign-magnitude form. Negation is done chunk-serially, one CHUNK-bit slice per cycle with a registered carry, so no 32-bit incrementer sits in the result path.

## Interface
- WIDTH, 32, data word width; must be a multiple of CHUNK (elaboration-time assertion).
- CHUNK, 8, bits negated per cycle; NCHUNK = WIDTH/CHUNK.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; high only in IDLE and while rst is low.
- in_data  input  WIDTH  two's-complement operand.
- out_valid  output  1  result is valid; held until out_ready.
- out_ready  input  1  consumer accepts the result.
- out_sign  output  1  sign of the operand (in_data MSB).
- out_mag  output  WIDTH  unsigned magnitude.
- out_zero  output  1  operand was zero.

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch in_data into an operand register, set out_sign=MSB, set out_zero=(in_data==0), set carry=1, set chunk index=0.
  - If MSB=0: out_mag<=in_data, go to DONE.
  - Else: go to CONV.
- CONV, one chunk k per cycle:
  - out_mag[k] <= ~op[k] + carry, where slice k is bits [k*CHUNK +: CHUNK].
  - carry <= carry-out of that addition.
  - Index increments; after chunk NCHUNK-1, go to DONE.
  - The carry out of the top chunk is discarded.
- DONE:
  - out_valid=1; out_sign, out_mag and out_zero are stable.
  - On out_ready, go to IDLE.
- Edge case: -2^(WIDTH-1) gives out_sign=1, out_mag=2^(WIDTH-1). This is correct as an unsigned value; no overflow flag is raised.
- Only one word is in flight at a time. in_ready is low in CONV and DONE; in_data is ignored there.

## Timing
- Reset values:
  - state=IDLE, out_valid=0, out_sign=0, out_mag=0, out_zero=0, carry=0, index=0.
  - in_ready=0 while rst is high, and 1 in the first cycle after rst deasserts.
- Latency is counted from the accept edge to the first cycle with out_valid high:
  - Non-negative operand: 1 cycle.
  - Negative operand: 1+NCHUNK cycles, which is 5 with the defaults.
- Throughput: the earliest next accept is the cycle after the out_valid/out_ready handshake, because IDLE is re-entered on that edge.
- out_valid high with out_ready low: all outputs hold indefinitely.
- out_ready is ignored when out_valid=0.
- in_valid is ignored when in_ready=0.
- rst during CONV or DONE: returns to IDLE on that edge, the partial result is discarded, and out_valid drops on the same edge.
- rst wins over a simultaneous accept or handshake.
- All outputs are registered or decoded from state; there is no combinational in-to-out path.

## Structure
- Shared package, sign_mag_pkg, holds:
  - the state typedef: enum logic [1:0] {IDLE, CONV, DONE};
  - the default WIDTH/CHUNK localparams;
  - the function chunk index width = $clog2(NCHUNK).
- One sub-module: chunk_negate_slice.
  - Combinational CHUNK-bit ~a + cin, producing sum and cout.
  - Instantiated once and fed by a mux on the operand slice.
- The top-level contains the FSM, chunk counter, carry register, operand register and the result register with per-chunk write enables.

## Test plan
- 0x0000_0005 accepted with out_ready=1 -> out_valid 1 cycle later; sign=0, mag=0x0000_0005, zero=0; in_ready high the cycle after the handshake.
- 0xFFFF_FFFB -> out_valid exactly 5 cycles after accept; sign=1, mag=0x0000_0005.
- Carry ripple across chunk boundaries:
  - 0xFFFF_FF00 -> mag=0x0000_0100.
  - 0xFFFF_FFFF -> mag=0x0000_0001.
  - 0x8000_0000 -> sign=1, mag=0x8000_0000.
- 0x0000_0000 -> sign=0, mag=0, zero=1, latency 1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid; outputs stay constant and in_ready stays 0.
  - Toggle in_data/in_valid during that window; the result is unaffected.
  - Release out_ready; the next word is accepted one cycle later.
- Assert rst on the 2nd CONV cycle of 0xFFFF_FFFB:
  - Next cycle: out_valid=0, out_mag=0, state IDLE.
  - After deassert, 0xFFFF_FFF6 -> sign=1, mag=0x0000_000A with no stale carry.
